// File: rtl/comp_window_filt_pkg.sv
// Shared class encoding for the windowed comparator and its persistence filter.
// Bit order {gt, aeq, eq, lt} follows the original comparator's port order.
package comp_window_filt_pkg;

   typedef logic [3:0] cls_t;

   localparam cls_t CLS_NONE = 4'b0000;
   localparam cls_t CLS_GT   = 4'b1000;
   localparam cls_t CLS_AEQ  = 4'b0100;
   localparam cls_t CLS_EQ   = 4'b0010;
   localparam cls_t CLS_LT   = 4'b0001;

endpackage

// File: rtl/comp_window_core.sv
// Combinational absolute difference and priority classifier (eq > aeq > gt > lt).
module comp_window_core
   import comp_window_filt_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic [W-1:0] tol_i,
   output logic [W-1:0] diff_o,
   output cls_t         cls_o
);

   logic [W-1:0] diff_s;

   // Subtract in whichever direction cannot wrap, then classify by priority.
   always_comb begin
      diff_s = {W{1'b0}};
      cls_o  = CLS_NONE;
      if (a_i >= b_i) begin
         diff_s = a_i - b_i;
      end else begin
         diff_s = b_i - a_i;
      end
      if (diff_s == {W{1'b0}}) begin
         cls_o = CLS_EQ;
      end else if (diff_s <= tol_i) begin
         cls_o = CLS_AEQ;
      end else if (a_i > b_i) begin
         cls_o = CLS_GT;
      end else begin
         cls_o = CLS_LT;
      end
   end

   assign diff_o = diff_s;

endmodule

// File: rtl/comp_window_filt.sv
// Two-stage windowed magnitude comparator with a persistence filter that only
// moves the stable class after PERSIST consecutive agreeing samples.
module comp_window_filt
   import comp_window_filt_pkg::*;
#(
   parameter  int W       = 8,
   parameter  int PERSIST = 3,
   localparam int CW      = $clog2(PERSIST + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] tol,
   output logic         out_valid,
   output logic         gt,
   output logic         aeq,
   output logic         eq,
   output logic         lt,
   output logic [W-1:0] diff,
   output logic         st_valid,
   output logic         st_gt,
   output logic         st_aeq,
   output logic         st_eq,
   output logic         st_lt,
   output logic         st_chg
);

   localparam logic [CW-1:0] RUN_ONE  = CW'(1);
   localparam logic [CW-1:0] RUN_FULL = CW'(PERSIST);

   logic         s1_valid_q;
   logic [W-1:0] a_q, b_q, tol_q;
   logic [W-1:0] diff_s;
   cls_t         cls_s;

   logic         out_valid_q;
   cls_t         cls_q;
   logic [W-1:0] diff_q;

   cls_t         cand_q, cand_d;
   logic [CW-1:0] run_q, run_d;
   logic         st_valid_q, st_valid_d;
   cls_t         st_cls_q, st_cls_d;
   logic         st_chg_q, st_chg_d;

   // Stage 1: capture operands on each accepted sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         a_q        <= {W{1'b0}};
         b_q        <= {W{1'b0}};
         tol_q      <= {W{1'b0}};
      end else begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            tol_q <= tol;
         end
      end
   end

   comp_window_core #(.W(W)) u_core (
      .a_i    (a_q),
      .b_i    (b_q),
      .tol_i  (tol_q),
      .diff_o (diff_s),
      .cls_o  (cls_s)
   );

   // Stage 2: register class and difference; diff holds across idle cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         cls_q       <= CLS_NONE;
         diff_q      <= {W{1'b0}};
      end else begin
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            cls_q  <= cls_s;
            diff_q <= diff_s;
         end else begin
            cls_q  <= CLS_NONE;
         end
      end
   end

   // Persistence filter: run length of the current candidate, commit on reaching PERSIST.
   always_comb begin
      cand_d     = cand_q;
      run_d      = run_q;
      st_valid_d = st_valid_q;
      st_cls_d   = st_cls_q;
      st_chg_d   = 1'b0;
      if (out_valid_q) begin
         if (cls_q == cand_q) begin
            if (run_q == RUN_FULL) begin
               run_d = run_q;
            end else begin
               run_d = run_q + RUN_ONE;
            end
         end else begin
            cand_d = cls_q;
            run_d  = RUN_ONE;
         end
         if ((run_d == RUN_FULL) && (!st_valid_q || (cand_d != st_cls_q))) begin
            st_cls_d   = cand_d;
            st_valid_d = 1'b1;
            st_chg_d   = 1'b1;
         end else begin
            st_chg_d   = 1'b0;
         end
      end else begin
         st_chg_d = 1'b0;
      end
   end

   // Filter state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cand_q     <= CLS_NONE;
         run_q      <= {CW{1'b0}};
         st_valid_q <= 1'b0;
         st_cls_q   <= CLS_NONE;
         st_chg_q   <= 1'b0;
      end else begin
         cand_q     <= cand_d;
         run_q      <= run_d;
         st_valid_q <= st_valid_d;
         st_cls_q   <= st_cls_d;
         st_chg_q   <= st_chg_d;
      end
   end

   assign out_valid = out_valid_q;
   assign gt        = cls_q[3];
   assign aeq       = cls_q[2];
   assign eq        = cls_q[1];
   assign lt        = cls_q[0];
   assign diff      = diff_q;
   assign st_valid  = st_valid_q;
   assign st_gt     = st_cls_q[3];
   assign st_aeq    = st_cls_q[2];
   assign st_eq     = st_cls_q[1];
   assign st_lt     = st_cls_q[0];
   assign st_chg    = st_chg_q;

endmodule

// File: tb/tb_comp_window_filt.sv
// Bench for comp_window_filt: a cycle-indexed reference model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_comp_window_filt;
   import comp_window_filt_pkg::*;

   localparam int W       = 8;
   localparam int PERSIST = 3;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic [W-1:0] a = 8'd0, b = 8'd0, tol = 8'd0;
   logic         out_valid, gt, aeq, eq, lt;
   logic [W-1:0] diff;
   logic         st_valid, st_gt, st_aeq, st_eq, st_lt, st_chg;

   always #5 clk = ~clk;

   comp_window_filt #(.W(W), .PERSIST(PERSIST)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .tol(tol),
      .out_valid(out_valid), .gt(gt), .aeq(aeq), .eq(eq), .lt(lt), .diff(diff),
      .st_valid(st_valid), .st_gt(st_gt), .st_aeq(st_aeq), .st_eq(st_eq),
      .st_lt(st_lt), .st_chg(st_chg)
   );

   wire [3:0]  dut_cls = {gt, aeq, eq, lt};
   wire [3:0]  dut_st  = {st_gt, st_aeq, st_eq, st_lt};
   wire [10:0] obs     = {out_valid, gt, aeq, eq, lt, st_valid, st_gt, st_aeq, st_eq, st_lt, st_chg};

   int tests = 0;
   int fails = 0;
   int edges = 0;

   typedef struct { int due; int a; int b; int t; } smp_t;
   typedef struct { int cyc; logic [3:0] cls; int diff; } rec_t;
   smp_t pend[$];
   rec_t raw_log[$];
   rec_t chg_log[$];

   int         m_diff = 0;
   logic       m_st_valid = 1'b0;
   logic [3:0] m_st_cls = 4'b0000;
   logic       m_chg = 1'b0;
   logic [3:0] m_last = 4'b0000;
   int         m_streak = 0;
   int         m_commits = 0;
   int         dut_chg_cnt = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, exp, edges);
      end
   endtask

   function automatic int absdiff(input int x, input int y);
      return (x > y) ? x - y : y - x;
   endfunction

   function automatic logic [3:0] ref_cls(input int x, input int y, input int t);
      int d = absdiff(x, y);
      if (d == 0) return CLS_EQ;
      if (d <= t) return CLS_AEQ;
      return (x > y) ? CLS_GT : CLS_LT;
   endfunction

   function automatic int find_raw(input int c);
      foreach (raw_log[i]) if (raw_log[i].cyc == c) return i;
      return -1;
   endfunction

   // Model side: note what the DUT accepts at each rising edge.
   initial forever begin
      @(posedge clk);
      edges++;
      if (rst) begin
         pend.delete();
         m_diff = 0; m_st_valid = 1'b0; m_st_cls = 4'b0000; m_chg = 1'b0;
         m_last = 4'b0000; m_streak = 0;
      end else if (in_valid) begin
         pend.push_back('{due: edges + 1, a: int'(a), b: int'(b), t: int'(tol)});
      end
   end

   // Compare every cycle on the falling edge, then advance the filter model.
   initial forever begin
      int n;
      logic       ev;
      logic [3:0] ecls;
      smp_t s;
      @(negedge clk);
      n = edges; ev = 1'b0; ecls = 4'b0000;
      if (pend.size() > 0 && pend[0].due == n) begin
         s = pend.pop_front();
         ev = 1'b1;
         ecls = ref_cls(s.a, s.b, s.t);
         m_diff = absdiff(s.a, s.b);
      end
      chk("out_valid", 32'(out_valid), 32'(ev));
      chk("raw_cls", 32'(dut_cls), 32'(ecls));
      chk("diff", 32'(diff), 32'(m_diff));
      chk("st_valid", 32'(st_valid), 32'(m_st_valid));
      chk("st_cls", 32'(dut_st), 32'(m_st_cls));
      chk("st_chg", 32'(st_chg), 32'(m_chg));
      if (st_valid) chk("st_onehot", 32'($countones(dut_st)), 32'd1);
      if (out_valid) raw_log.push_back('{cyc: n, cls: dut_cls, diff: int'(diff)});
      if (st_chg) begin
         chg_log.push_back('{cyc: n, cls: dut_st, diff: 0});
         dut_chg_cnt++;
      end
      m_chg = 1'b0;
      if (ev) begin
         if (ecls == m_last) m_streak++;
         else begin m_last = ecls; m_streak = 1; end
         if (m_streak >= PERSIST && (!m_st_valid || m_st_cls != ecls)) begin
            m_st_valid = 1'b1; m_st_cls = ecls; m_chg = 1'b1; m_commits++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic v, input int x, input int y, input int t);
      in_valid = v; a = W'(x); b = W'(y); tol = W'(t);
   endtask

   task automatic chk_raw(input string nm, input int c, input logic [3:0] ecls, input int ediff);
      int i = find_raw(c);
      chk({nm, "_present"}, 32'(i >= 0), 32'd1);
      if (i >= 0) begin
         chk({nm, "_cls"}, 32'(raw_log[i].cls), 32'(ecls));
         chk({nm, "_diff"}, 32'(raw_log[i].diff), 32'(ediff));
      end
   endtask

   initial begin
      int k0, c0_model, c0_dut;
      // Power-up reset.
      tick(); tick();
      @(negedge clk);
      chk("reset_obs", 32'(obs), 32'd0);
      chk("reset_diff", 32'(diff), 32'd0);
      tick(); rst = 1'b0;

      // Mid-stream reset after a stable gt has formed.
      for (int i = 0; i < 4; i++) begin put(1'b1, 100, 10, 5); tick(); end
      put(1'b0, 0, 0, 0); tick();
      @(negedge clk);
      chk("pre_reset_st_valid", 32'(st_valid), 32'd1);
      tick(); rst = 1'b1; put(1'b1, 100, 10, 5);
      tick(); put(1'b0, 0, 0, 0);
      tick(); rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_reset_obs", 32'(obs), 32'd0);
         tick();
      end

      // Raw classes back-to-back.
      raw_log.delete();
      k0 = edges;
      put(1'b1, 50, 50, 2); tick();
      put(1'b1, 52, 50, 2); tick();
      put(1'b1, 48, 50, 2); tick();
      put(1'b1, 60, 50, 2); tick();
      put(1'b1, 40, 50, 2); tick();
      put(1'b0, 0, 0, 0);
      repeat (4) tick();
      chk("raw_latency", 32'(find_raw(k0 + 1) >= 0), 32'd0);
      chk("raw_count", 32'(raw_log.size()), 32'd5);
      chk_raw("eq50", k0 + 2, 4'b0010, 0);
      chk_raw("aeq52", k0 + 3, 4'b0100, 2);
      chk_raw("aeq48", k0 + 4, 4'b0100, 2);
      chk_raw("gt60", k0 + 5, 4'b1000, 10);
      chk_raw("lt40", k0 + 6, 4'b0001, 10);

      // Width extremes.
      raw_log.delete();
      k0 = edges;
      put(1'b1, 255, 0, 0);   tick();
      put(1'b1, 0, 255, 254); tick();
      put(1'b1, 0, 255, 255); tick();
      put(1'b1, 200, 201, 0); tick();
      put(1'b0, 0, 0, 0);
      repeat (4) tick();
      chk_raw("ext_gt255", k0 + 2, 4'b1000, 255);
      chk_raw("ext_lt254", k0 + 3, 4'b0001, 255);
      chk_raw("ext_aeq255", k0 + 4, 4'b0100, 255);
      chk_raw("ext_lt0", k0 + 5, 4'b0001, 1);

      // Persistence: gt gt lt gt gt gt from a cleared filter.
      rst = 1'b1; tick(); rst = 1'b0;
      chg_log.delete();
      k0 = edges;
      put(1'b1, 100, 10, 5); tick();
      put(1'b1, 100, 10, 5); tick();
      put(1'b1, 10, 100, 5); tick();
      put(1'b1, 100, 10, 5); tick();
      put(1'b1, 100, 10, 5); tick();
      put(1'b1, 100, 10, 5); tick();
      put(1'b0, 0, 0, 0);
      repeat (5) tick();
      chk("persist_chg_count", 32'(chg_log.size()), 32'd1);
      if (chg_log.size() > 0) begin
         chk("persist_chg_cyc", 32'(chg_log[0].cyc), 32'(k0 + 8));
         chk("persist_chg_cls", 32'(chg_log[0].cls), 32'(4'b1000));
      end

      // Hold through a gap: lt lt, 5 idle, lt.
      chg_log.delete();
      k0 = edges;
      put(1'b1, 10, 100, 5); tick();
      put(1'b1, 10, 100, 5); tick();
      put(1'b0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("gap_st_gt", 32'(st_gt), 32'd1);
         chk("gap_st_lt", 32'(st_lt), 32'd0);
         tick();
      end
      put(1'b1, 10, 100, 5); tick();
      put(1'b0, 0, 0, 0);
      repeat (4) tick();
      chk("gap_chg_count", 32'(chg_log.size()), 32'd1);
      if (chg_log.size() > 0) begin
         chk("gap_chg_cyc", 32'(chg_log[0].cyc), 32'(k0 + 10));
         chk("gap_chg_cls", 32'(chg_log[0].cls), 32'(4'b0001));
      end

      // Random samples; the per-cycle compare does the checking.
      c0_model = m_commits;
      c0_dut   = dut_chg_cnt;
      for (int i = 0; i < 1000; i++) begin
         int x, y, t, mode;
         x = int'($urandom_range(0, 255));
         mode = int'($urandom_range(0, 3));
         if (mode == 0) y = x;
         else if (mode == 1) y = (x + int'($urandom_range(0, 6)) - 3) & 255;
         else y = int'($urandom_range(0, 255));
         mode = int'($urandom_range(0, 3));
         if (mode == 0) t = 0;
         else if (mode == 1) t = 255;
         else t = int'($urandom_range(0, 8));
         put(($urandom_range(0, 3) != 0), x, y, t);
         tick();
      end
      put(1'b0, 0, 0, 0);
      repeat (5) tick();
      chk("rand_commit_count", 32'(dut_chg_cnt - c0_dut), 32'(m_commits - c0_model));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/comp_window_filt.md
Name: comp_window_filt

Overview:
- Parametrised, pipelined successor to the 4-bit four-output magnitude comparator.
- Classifies each valid (a, b) sample as gt, aeq, eq or lt, using a run-time tolerance window, and reports the absolute difference.
- A persistence filter holds a stable class that changes only after PERSIST consecutive samples agree.
- Sits between sampled sensor/counter datapaths and control logic that must not chatter on near-equal inputs.

Parameters:
- W, 8: operand width in bits (W >= 2).
- PERSIST, 3: consecutive identical raw classifications required to update the stable class (PERSIST >= 1).
- CW, $clog2(PERSIST+1): run-counter width (localparam, not overridable).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sample strobe; a, b, tol are captured only when high.
- a  in  W  operand A, unsigned.
- b  in  W  operand B, unsigned.
- tol  in  W  tolerance window, unsigned, sampled together with a and b.
- out_valid  out  1  raw outputs valid, 2 cycles after in_valid.
- gt, aeq, eq, lt  out  1 each  raw one-hot class of the sample.
- diff  out  W  |a - b| of the sample.
- st_valid  out  1  stable class has been established at least once.
- st_gt, st_aeq, st_eq, st_lt  out  1 each  filtered one-hot stable class.
- st_chg  out  1  one-cycle pulse when the stable class is set or changes.

Behaviour:
- Reset (rst high at an edge): every output goes to 0. Pipeline valids, the candidate class and the run counter also clear. Reset mid-operation discards all in-flight samples; nothing emerges after reset deasserts except new samples.
- Stage 1 (edge where in_valid is high):
  - Register a, b and tol.
  - diff = a >= b ? a - b : b - a, computed at W bits with no overflow.
- Stage 2: classify and register.
  - Priority: eq if diff == 0; else aeq if diff <= tol; else gt if a > b; else lt.
  - Exactly one class bit is high whenever out_valid is high. All four are 0 when out_valid is low.
  - diff holds its last value when out_valid is low.
- Raw outputs are valid exactly 2 cycles after the in_valid edge. Back-to-back in_valid gives one result per cycle. No backpressure.
- tol == 0: the aeq class is unreachable.
- tol >= 2^W - 1: every unequal pair classifies as aeq.
- Persistence filter (updates only on cycles where out_valid is high):
  - State: cand[3:0] (class under test), run[CW-1:0].
  - Raw class == cand: run <= run + 1, saturating at PERSIST.
  - Raw class != cand: cand <= raw class, run <= 1.
  - Commit: when the post-update run == PERSIST and cand != stable class (or st_valid == 0), load cand into the st_* bits the same cycle, set st_valid = 1, and pulse st_chg for one cycle.
  - The committed st_* values are visible the cycle after the qualifying out_valid.
  - PERSIST == 1: every raw class change commits immediately.
- Gaps in in_valid do not reset run. Only a differing class or rst resets it.
- Stable outputs hold through gaps and never glitch between commits.

Decomposition:
- Shared package/include: class encoding constants CLS_GT = 4'b1000, CLS_AEQ = 4'b0100, CLS_EQ = 4'b0010, CLS_LT = 4'b0001. These are ordered {gt, aeq, eq, lt} to match the existing comparator's port order, and are reused by benches.
- One natural sub-module, comp_window_core: combinational abs-diff plus priority classifier, W-parametrised, instantiated in stage 2.
- The filter stays inline in the top module.

Test Plan (W=8, PERSIST=3):
- Reset: rst high for 2 cycles mid-stream with in_valid toggling -> all outputs 0 and no out_valid for 2 cycles after release; st_valid = 0.
- Raw classes, back-to-back: (a=50, b=50, tol=2), (52, 50, 2), (48, 50, 2), (60, 50, 2), (40, 50, 2) -> out_valid on 5 consecutive cycles, starting 2 cycles after the first in_valid. Classes eq, aeq, aeq, gt, lt; diff 0, 2, 2, 10, 10.
- Width extremes: (255, 0, 0) -> gt, diff = 255. (0, 255, 254) -> lt. (0, 255, 255) -> aeq. (200, 201, 0) -> lt.
- Persistence: gt, gt, lt, gt, gt, gt -> st_chg pulses once, the cycle after the 6th out_valid, with st_gt = 1. No stable update before that.
- Hold and gap: after stable gt, inject lt, lt, then 5 idle cycles, then lt -> stable switches to st_lt with one st_chg pulse on the third lt. st_gt stays high throughout the gap.
- Random: 1000 random (a, b, tol) samples with random in_valid -> raw outputs match a reference model; one-hot always holds; st_chg count equals the model's commit count.
